regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter_pkg.sv | 20 ++
 rtl/regfile_wb_arbiter_if.sv | 33 +++
 rtl/regfile_wb_arbiter_wb_fifo.sv | 76 +++++++
 rtl/regfile_wb_arbiter.sv | 101 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 64;
    localparam int NUM_REGS   = 32;

    // Writeback source identifiers; also the encoding of GrantSrc.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

    // One queued writeback: destination register and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] Rd;
        logic [REG_DATA_W-1:0] Data;
    } wb_entry;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the two writeback request channels and the register-file write port.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
);
    logic                     AluValid;
    logic                     AluReady;
    logic [ADDR_W-1:0]        AluRd;
    logic [DATA_W-1:0]        AluData;
    logic                     MemValid;
    logic                     MemReady;
    logic [ADDR_W-1:0]        MemRd;
    logic [DATA_W-1:0]        MemData;
    logic [ADDR_W-1:0]        RW;
    logic [DATA_W-1:0]        BusW;
    logic                     RegWr;
    logic [(1<<ADDR_W)-1:0]   Pending;
    logic                     GrantSrc;

    // Writeback producers / register-file side.
    modport master (
        output AluValid, AluRd, AluData, MemValid, MemRd, MemData,
        input  AluReady, MemReady, RW, BusW, RegWr, Pending, GrantSrc
    );

    // The arbiter itself.
    modport slave (
        input  AluValid, AluRd, AluData, MemValid, MemRd, MemData,
        output AluReady, MemReady, RW, BusW, RegWr, Pending, GrantSrc
    );
endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small synchronous FIFO holding pending writebacks for one source.
// Exposes the head entry and a per-slot valid/Rd view for hazard decode.
module wb_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    input  logic                         PushValid,
    output logic                         PushReady,
    input  logic [ADDR_W-1:0]            PushRd,
    input  logic [DATA_W-1:0]            PushData,
    input  logic                         Pop,
    output logic                         HeadValid,
    output logic [ADDR_W-1:0]            HeadRd,
    output logic [DATA_W-1:0]            HeadData,
    output logic [DEPTH-1:0]             EntryValid,
    output logic [DEPTH-1:0][ADDR_W-1:0] EntryRd
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0]  rdPtrReg;
    logic [PTR_W-1:0]  wrPtrReg;
    logic [PTR_W:0]    countReg;
    logic [ADDR_W-1:0] rdMem   [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic              doPush;
    logic              doPop;

    // Ready looks only at the registered count, so a full FIFO refuses a
    // push even when the arbiter pops it in the same cycle.
    assign PushReady = (countReg != CNT_FULL);
    assign HeadValid = (countReg != '0);
    assign doPush    = PushValid && PushReady;
    assign doPop     = Pop && HeadValid;
    assign HeadRd    = rdMem[rdPtrReg];
    assign HeadData  = dataMem[rdPtrReg];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rdPtrReg <= '0;
            wrPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (doPush) wrPtrReg <= wrPtrReg + PTR_ONE;
            if (doPop)  rdPtrReg <= rdPtrReg + PTR_ONE;
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + CNT_ONE;
                2'b01:   countReg <= countReg - CNT_ONE;
                default: countReg <= countReg;
            endcase
        end
    end

    // Entry storage; contents need no reset because occupancy gates every use.
    always_ff @(posedge Clk) begin
        if (doPush) begin
            rdMem[wrPtrReg]   <= PushRd;
            dataMem[wrPtrReg] <= PushData;
        end
    end

    // A slot is occupied when its distance from the read pointer is below the count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gSlot
        logic [PTR_W-1:0] offs;
        assign offs           = PTR_W'(gi) - rdPtrReg;
        assign EntryValid[gi] = ({1'b0, offs} < countReg);
        assign EntryRd[gi]    = rdMem[gi];
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// the ALU and load writeback queues, plus a pending-write scoreboard.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int REG_COUNT = 1 << ADDR_W;

    logic                         aluHeadValid, memHeadValid;
    logic [ADDR_W-1:0]            aluHeadRd, memHeadRd;
    logic [DATA_W-1:0]            aluHeadData, memHeadData;
    logic [DEPTH-1:0]             aluEntryValid, memEntryValid;
    logic [DEPTH-1:0][ADDR_W-1:0] aluEntryRd, memEntryRd;
    logic                         grantMem, aluPop, memPop;

    logic                         regWrReg;
    logic [ADDR_W-1:0]            rwReg;
    logic [DATA_W-1:0]            busWReg;
    wb_src_e                      grantSrcReg;
    wb_src_e                      lastGrantReg;
    logic [REG_COUNT-1:0]         pendingVec;

    wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) aluFifo (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .PushValid  (bus.AluValid),
        .PushReady  (bus.AluReady),
        .PushRd     (bus.AluRd),
        .PushData   (bus.AluData),
        .Pop        (aluPop),
        .HeadValid  (aluHeadValid),
        .HeadRd     (aluHeadRd),
        .HeadData   (aluHeadData),
        .EntryValid (aluEntryValid),
        .EntryRd    (aluEntryRd)
    );

    wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) memFifo (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .PushValid  (bus.MemValid),
        .PushReady  (bus.MemReady),
        .PushRd     (bus.MemRd),
        .PushData   (bus.MemData),
        .Pop        (memPop),
        .HeadValid  (memHeadValid),
        .HeadRd     (memHeadRd),
        .HeadData   (memHeadData),
        .EntryValid (memEntryValid),
        .EntryRd    (memEntryRd)
    );

    // MEM wins when it is the only requester, or when both request and ALU went last.
    assign grantMem = memHeadValid && (!aluHeadValid || (lastGrantReg == SRC_ALU));
    assign aluPop   = aluHeadValid && !grantMem;
    assign memPop   = grantMem;

    // Registered write port: RW/BusW hold through idle cycles so they stay
    // stable across the register file's negedge commit.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            regWrReg     <= 1'b0;
            rwReg        <= '0;
            busWReg      <= '0;
            grantSrcReg  <= SRC_ALU;
            lastGrantReg <= SRC_MEM;
        end else if (aluPop || memPop) begin
            regWrReg     <= 1'b1;
            rwReg        <= grantMem ? memHeadRd   : aluHeadRd;
            busWReg      <= grantMem ? memHeadData : aluHeadData;
            grantSrcReg  <= grantMem ? SRC_MEM : SRC_ALU;
            lastGrantReg <= grantMem ? SRC_MEM : SRC_ALU;
        end else begin
            regWrReg     <= 1'b0;
        end
    end

    // Scoreboard: every queued destination plus the one being written now.
    always_comb begin
        pendingVec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (aluEntryValid[i]) pendingVec[aluEntryRd[i]] = 1'b1;
            if (memEntryValid[i]) pendingVec[memEntryRd[i]] = 1'b1;
        end
        if (regWrReg) pendingVec[rwReg] = 1'b1;
    end

    assign bus.RegWr    = regWrReg;
    assign bus.RW       = rwReg;
    assign bus.BusW     = busWReg;
    assign bus.GrantSrc = grantSrcReg;
    assign bus.Pending  = pendingVec;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scoreboard bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        logic        src;
    } exp_t;

    logic    Clk   = 1'b0;
    logic    Rst_n = 1'b0;
    int      compared   = 0;
    int      mismatched = 0;
    exp_t    expQ[$];
    wb_entry aluStim[$];
    wb_entry memStim[$];

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.DEPTH(2), .DATA_W(64), .ADDR_W(5)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic sendAlu(input logic [4:0] rd, input logic [63:0] d);
        wb_entry e;
        e.Rd = rd; e.Data = d;
        aluStim.push_back(e);
    endtask

    task automatic sendMem(input logic [4:0] rd, input logic [63:0] d);
        wb_entry e;
        e.Rd = rd; e.Data = d;
        memStim.push_back(e);
    endtask

    task automatic expWrite(input logic [4:0] rd, input logic [63:0] d, input logic s);
        exp_t e;
        e.rd = rd; e.data = d; e.src = s;
        expQ.push_back(e);
    endtask

    task automatic waitEdge();
        @(posedge Clk);
        #2;
    endtask

    task automatic doReset();
        @(negedge Clk);
        Rst_n = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    // ALU source: holds each entry until a handshake completes.
    initial begin : aluDrv
        logic fire;
        bus.AluValid = 1'b0;
        bus.AluRd    = '0;
        bus.AluData  = '0;
        forever begin
            @(negedge Clk);
            fire = bus.AluValid && bus.AluReady && Rst_n;
            @(posedge Clk);
            #1;
            if (fire && aluStim.size() > 0) aluStim.delete(0);
            if (aluStim.size() > 0) begin
                bus.AluValid = 1'b1;
                bus.AluRd    = aluStim[0].Rd;
                bus.AluData  = aluStim[0].Data;
            end else begin
                bus.AluValid = 1'b0;
            end
        end
    end

    // MEM source: same handshake discipline.
    initial begin : memDrv
        logic fire;
        bus.MemValid = 1'b0;
        bus.MemRd    = '0;
        bus.MemData  = '0;
        forever begin
            @(negedge Clk);
            fire = bus.MemValid && bus.MemReady && Rst_n;
            @(posedge Clk);
            #1;
            if (fire && memStim.size() > 0) memStim.delete(0);
            if (memStim.size() > 0) begin
                bus.MemValid = 1'b1;
                bus.MemRd    = memStim[0].Rd;
                bus.MemData  = memStim[0].Data;
            end else begin
                bus.MemValid = 1'b0;
            end
        end
    end

    // Monitor: every register-file write must match the next expected entry.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Rst_n && bus.RegWr) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_write: got RW=%0d BusW=%0h, expected no write (t=%0t)",
                             bus.RW, bus.BusW, $time);
                end else begin
                    e = expQ.pop_front();
                    $display("write RW=%0d BusW=%0h src=%0d (t=%0t)", bus.RW, bus.BusW, bus.GrantSrc, $time);
                    check("wr_rw",   64'(bus.RW),       64'(e.rd));
                    check("wr_busw", bus.BusW,          e.data);
                    check("wr_src",  64'(bus.GrantSrc), 64'(e.src));
                end
            end
        end
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        // Reset state
        #1;
        check("rst_regwr",    64'(bus.RegWr),    64'd0);
        check("rst_pending",  64'(bus.Pending),  64'd0);
        check("rst_aluready", 64'(bus.AluReady), 64'd1);
        check("rst_memready", 64'(bus.MemReady), 64'd1);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        waitEdge();
        check("rst_rw",       64'(bus.RW),       64'd0);
        check("rst_busw",     bus.BusW,          64'd0);
        check("rst_grantsrc", 64'(bus.GrantSrc), 64'd0);

        // Single ALU write, latency, Pending window, idle hold
        @(negedge Clk); #2;
        sendAlu(5'd5, 64'hDEAD_BEEF);
        expWrite(5'd5, 64'hDEAD_BEEF, 1'b0);
        @(posedge Clk);
        waitEdge();                                   // edge N
        check("single_pend_n",   64'(bus.Pending), 64'h20);
        check("single_regwr_n",  64'(bus.RegWr),   64'd0);
        waitEdge();                                   // edge N+1
        check("single_regwr_n1", 64'(bus.RegWr),   64'd1);
        check("single_pend_n1",  64'(bus.Pending), 64'h20);
        waitEdge();                                   // edge N+2
        check("idle_regwr",      64'(bus.RegWr),   64'd0);
        check("idle_rw_hold",    64'(bus.RW),      64'd5);
        check("idle_busw_hold",  bus.BusW,         64'hDEAD_BEEF);
        check("idle_pending",    64'(bus.Pending), 64'd0);

        // Contention: strict alternation, ALU first after reset
        doReset();
        @(negedge Clk); #2;
        for (int k = 0; k < 3; k++) begin
            sendAlu(5'(1 + k),  64'hAAAA_0000_0000_0000 + 64'(1 + k));
            sendMem(5'(10 + k), 64'hBBBB_0000_0000_0000 + 64'(10 + k));
        end
        expWrite(5'd1,  64'hAAAA_0000_0000_0001, 1'b0);
        expWrite(5'd10, 64'hBBBB_0000_0000_000A, 1'b1);
        expWrite(5'd2,  64'hAAAA_0000_0000_0002, 1'b0);
        expWrite(5'd11, 64'hBBBB_0000_0000_000B, 1'b1);
        expWrite(5'd3,  64'hAAAA_0000_0000_0003, 1'b0);
        expWrite(5'd12, 64'hBBBB_0000_0000_000C, 1'b1);
        @(posedge Clk);
        waitEdge();                                   // edge 1: both hold one
        check("cont_memready_e1", 64'(bus.MemReady), 64'd1);
        waitEdge();                                   // edge 2: MEM full
        check("cont_memready_full", 64'(bus.MemReady), 64'd0);
        waitEdge();                                   // edge 3: ALU full
        check("cont_aluready_full", 64'(bus.AluReady), 64'd0);
        check("cont_memready_e3",   64'(bus.MemReady), 64'd1);
        repeat (6) waitEdge();
        check("cont_stim_drained", 64'(aluStim.size() + memStim.size()), 64'd0);

        // MEM-only burst: push and pop every cycle, pointers wrap
        @(negedge Clk); #2;
        for (int k = 0; k < 4; k++) begin
            sendMem(5'(20 + k), 64'hC0DE_0000_0000_0000 + 64'(20 + k));
            expWrite(5'(20 + k), 64'hC0DE_0000_0000_0000 + 64'(20 + k), 1'b1);
        end
        repeat (8) waitEdge();
        check("burst_stim_drained", 64'(memStim.size()), 64'd0);
        check("burst_pending",      64'(bus.Pending),    64'd0);

        // Pending aggregation on register 7
        doReset();
        @(negedge Clk); #2;
        sendAlu(5'd7, 64'h77A);
        sendMem(5'd7, 64'h77B);
        expWrite(5'd7, 64'h77A, 1'b0);
        expWrite(5'd7, 64'h77B, 1'b1);
        @(posedge Clk);
        waitEdge();
        check("pend7_queued",  64'(bus.Pending),  64'h80);
        waitEdge();
        check("pend7_first",   64'(bus.Pending),  64'h80);
        check("pend7_src0",    64'(bus.GrantSrc), 64'd0);
        waitEdge();
        check("pend7_second",  64'(bus.Pending),  64'h80);
        check("pend7_src1",    64'(bus.GrantSrc), 64'd1);
        waitEdge();
        check("pend7_cleared", 64'(bus.Pending),  64'd0);

        // Reset mid-stream with queued entries
        doReset();
        @(negedge Clk); #2;
        sendAlu(5'd1, 64'h1111);  sendAlu(5'd2, 64'h2222);
        sendMem(5'd10, 64'hAAAA); sendMem(5'd11, 64'hBBBB);
        expWrite(5'd1,  64'h1111, 1'b0);
        expWrite(5'd10, 64'hAAAA, 1'b1);
        @(posedge Clk);
        waitEdge();                                   // R1
        check("mid_pend_r1",     64'(bus.Pending),  64'h402);
        waitEdge();                                   // R2
        check("mid_pend_r2",     64'(bus.Pending),  64'hC06);
        check("mid_memready_r2", 64'(bus.MemReady), 64'd0);
        waitEdge();                                   // R3
        check("mid_pend_r3",     64'(bus.Pending),  64'hC04);
        @(negedge Clk); #2;
        Rst_n = 1'b0;
        #1;
        check("mid_rst_regwr",    64'(bus.RegWr),    64'd0);
        check("mid_rst_pending",  64'(bus.Pending),  64'd0);
        check("mid_rst_aluready", 64'(bus.AluReady), 64'd1);
        check("mid_rst_memready", 64'(bus.MemReady), 64'd1);
        check("mid_rst_rw",       64'(bus.RW),       64'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (4) waitEdge();
        check("mid_after_regwr",   64'(bus.RegWr),   64'd0);
        check("mid_after_pending", 64'(bus.Pending), 64'd0);

        check("expq_empty", 64'(expQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
